// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: the hex glyph table,
// the decimal-point bit position and the scan state encoding.
package seg7_pkg;

  typedef enum logic {BLANK, SHOW} scan_state_e;

  localparam int SEG_DP = 7;

  // Active-high gfedcba glyphs for hex digits 0..F
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Bundle between the value-producing logic (master) and the scan driver (slave).
interface seg7_scan_mux_if #(parameter int DIGITS = 4);

  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                lz_suppress;
  logic [7:0]          segments;
  logic [DIGITS-1:0]   digit_sel;
  logic                frame_start;

  modport master (
    output value, dp, blank, lz_suppress,
    input  segments, digit_sel, frame_start
  );

  modport slave (
    input  value, dp, blank, lz_suppress,
    output segments, digit_sel, frame_start
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational glyph decode for one digit; produces an active-high
// {dp,g,f,e,d,c,b,a} pattern. Polarity is handled by the caller.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  input  logic       suppress,
  output logic [7:0] pattern
);

  // Blank darkens everything; a suppressed digit keeps only its dp
  always_comb begin
    pattern = '0;
    if (!blank) begin
      pattern[SEG_DP] = dp;
      if (!suppress) pattern[6:0] = SEG7_HEX[nibble];
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: one digit per slot, dead-time blank at
// the start of each slot, inputs snapshotted once per frame to avoid tearing.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 16,
  parameter bit SEG_INV      = 1'b1,
  parameter bit DIG_INV      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_mux_if.slave   bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF    = SEG_INV ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF    = DIG_INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  scan_state_e         state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   snap_blank;
  logic                snap_lz;
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic                fs_q;

  logic [DIGITS-1:0]   suppress;
  logic                zeros_above;
  logic [3:0]          cur_nibble;
  logic [7:0]          pattern;
  logic [DIGITS-1:0]   onehot;
  logic                frame_edge;

  // Walk from the most significant digit down; a digit is a leading zero
  // while it and everything above it is zero. Digit 0 always shows.
  always_comb begin
    zeros_above = 1'b1;
    suppress    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeros_above = zeros_above && (snap_value[4*i +: 4] == 4'h0);
      suppress[i] = snap_lz && (i != 0) && zeros_above;
    end
  end

  assign cur_nibble = snap_value[4*idx +: 4];
  assign onehot     = DIGITS'(1) << idx;
  assign frame_edge = (state == BLANK) && (idx == '0) && (cnt == '0);

  seg7_decode u_decode (
    .nibble   (cur_nibble),
    .dp       (snap_dp[idx]),
    .blank    (snap_blank[idx]),
    .suppress (suppress[idx]),
    .pattern  (pattern)
  );

  // Outputs are registered from the current slot position, so every output
  // trails the counter by exactly one cycle and stays mutually aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lz    <= 1'b0;
      seg_q      <= SEG_OFF;
      sel_q      <= SEL_OFF;
      fs_q       <= 1'b0;
    end else begin
      fs_q <= frame_edge;
      if (frame_edge) begin
        snap_value <= bus.value;
        snap_dp    <= bus.dp;
        snap_blank <= bus.blank;
        snap_lz    <= bus.lz_suppress;
      end
      if (state == SHOW) begin
        seg_q <= SEG_INV ? ~pattern : pattern;
        sel_q <= DIG_INV ? ~onehot : onehot;
      end else begin
        seg_q <= SEG_OFF;
        sel_q <= SEL_OFF;
      end
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        state <= BLANK;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == BLANK_LAST) state <= SHOW;
      end
    end
  end

  assign bus.segments    = seg_q;
  assign bus.digit_sel   = sel_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux with a small 4-digit configuration,
// checked every cycle against a frame-level behavioural model.
module tb_seg7_scan_mux;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int BLANK_C  = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   k;

  logic [15:0] snap_value;
  logic [3:0]  snap_dp;
  logic [3:0]  snap_blank;
  logic        snap_lz;
  logic [6:0]  hex_tab [16];

  seg7_scan_mux_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_mux #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_C),
    .SEG_INV      (1'b1),
    .DIG_INV      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] exp_seg,
                             input logic [3:0] exp_sel, input logic exp_fs);
    checks++;
    assert (bus.segments === exp_seg) else begin
      failures++;
      $error("[TB] FAIL %s segments: got %h, expected %h (k=%0d)", tag, bus.segments, exp_seg, k);
    end
    checks++;
    assert (bus.digit_sel === exp_sel) else begin
      failures++;
      $error("[TB] FAIL %s digit_sel: got %b, expected %b (k=%0d)", tag, bus.digit_sel, exp_sel, k);
    end
    checks++;
    assert (bus.frame_start === exp_fs) else begin
      failures++;
      $error("[TB] FAIL %s frame_start: got %b, expected %b (k=%0d)", tag, bus.frame_start, exp_fs, k);
    end
  endtask

  // Output cycle k (k>=1 after reset release) shows slot position p=k-1
  task automatic modelAndCheck(input string tag);
    int p, slot, pos;
    logic [7:0] pat;
    logic [7:0] exp_seg;
    logic [3:0] exp_sel;
    p    = k - 1;
    slot = (p / SCAN_DIV) % DIGITS;
    pos  = p % SCAN_DIV;
    if (pos < BLANK_C) begin
      exp_seg = 8'hFF;
      exp_sel = 4'hF;
    end else begin
      if (snap_blank[slot])
        pat = 8'h00;
      else if (snap_lz && slot > 0 && (snap_value >> (4 * slot)) == 16'h0)
        pat = {snap_dp[slot], 7'h00};
      else
        pat = {snap_dp[slot], hex_tab[(snap_value >> (4 * slot)) & 16'hF]};
      exp_seg = ~pat;
      exp_sel = ~(4'b0001 << slot);
    end
    checkOutput(tag, exp_seg, exp_sel, (p % FRAME) == 0);
  endtask

  task automatic applyStimulus(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      k++;
      if (((k - 1) % FRAME) == 0) begin
        snap_value = bus.value;
        snap_dp    = bus.dp;
        snap_blank = bus.blank;
        snap_lz    = bus.lz_suppress;
      end
      modelAndCheck(tag);
    end
  endtask

  task automatic setInputs(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] b, input logic lz);
    bus.value       = v;
    bus.dp          = d;
    bus.blank       = b;
    bus.lz_suppress = lz;
  endtask

  initial begin
    int guard;
    logic [15:0] rv;
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    checks = 0;
    failures = 0;
    k = 0;
    rst_n = 1'b0;
    setInputs(16'h12AF, 4'h0, 4'h0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_hold", 8'hFF, 4'hF, 1'b0);
    rst_n = 1'b1;

    applyStimulus("hex_12AF", 2 * FRAME);

    setInputs(16'h0050, 4'h0, 4'h0, 1'b1);
    applyStimulus("lz_0050", 2 * FRAME);
    setInputs(16'h0000, 4'h0, 4'h0, 1'b1);
    applyStimulus("lz_zero", 2 * FRAME);

    setInputs(16'h0200, 4'b0100, 4'b0001, 1'b0);
    applyStimulus("dp_blank", 2 * FRAME);
    setInputs(16'h0000, 4'b0010, 4'h0, 1'b1);
    applyStimulus("lz_dp", 2 * FRAME);

    // Mid-frame change during digit 1's slot must not tear the frame
    setInputs(16'h12AF, 4'h0, 4'h0, 1'b0);
    applyStimulus("pre_tear", FRAME - (k % FRAME) + SCAN_DIV + 4);
    setInputs(16'h0001, 4'h0, 4'h0, 1'b0);
    applyStimulus("tear", 2 * FRAME);

    for (int r = 0; r < 25; r++) begin
      rv = 16'($urandom);
      rv = rv >> (4 * $urandom_range(0, 4));
      setInputs(rv, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                1'($urandom));
      applyStimulus("random", $urandom_range(5, 45));
    end

    // Stop on digit 2, position 5, then hit reset between edges
    guard = 0;
    while (((k - 1) % FRAME) != 2 * SCAN_DIV + 5 && guard < 2 * FRAME) begin
      applyStimulus("seek_d2", 1);
      guard++;
    end
    checks++;
    assert (guard < 2 * FRAME) else begin
      failures++;
      $error("[TB] FAIL seek_d2: budget %0d exhausted, expected position reached", guard);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 8'hFF, 4'hF, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_again", 8'hFF, 4'hF, 1'b0);
    setInputs(16'hC0DE, 4'b1001, 4'h0, 1'b0);
    rst_n = 1'b1;
    k = 0;
    applyStimulus("after_reset", 2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
